// File: rtl/addr_dec_resp_mux_multi_outstanding_if.sv
// Master-side request/response bundle for the multi-outstanding address decoder.
// The master modport is the environment view; the slave modport is the decoder's view.
interface addr_dec_resp_mux_multi_outstanding_if #(
    parameter int unsigned NumOut         = 32,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 4
);
    localparam int unsigned LogNumOut = (NumOut > 1) ? $clog2(NumOut) : 1;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

    logic                                   req_i;
    logic [LogNumOut-1:0]                   add_i;
    logic [ReqDataWidth-1:0]                data_i;
    logic                                   gnt_o;
    logic                                   vld_o;
    logic [RespDataWidth-1:0]               rdata_o;
    logic [NumOut-1:0]                      req_o;
    logic [NumOut-1:0]                      gnt_i;
    logic [NumOut-1:0]                      vld_i;
    logic [NumOut-1:0][ReqDataWidth-1:0]    data_o;
    logic [NumOut-1:0][RespDataWidth-1:0]   rdata_i;
    logic [CntWidth-1:0]                    outstanding_o;
    logic                                   spurious_o;

    modport master (
        output req_i, add_i, data_i, gnt_i, vld_i, rdata_i,
        input  gnt_o, vld_o, rdata_o, req_o, data_o, outstanding_o, spurious_o
    );

    modport slave (
        input  req_i, add_i, data_i, gnt_i, vld_i, rdata_i,
        output gnt_o, vld_o, rdata_o, req_o, data_o, outstanding_o, spurious_o
    );
endinterface

// File: rtl/addr_dec_resp_mux_multi_outstanding.sv
// Decodes one master onto NumOut banks with up to MaxOutstanding in-flight requests to a single bank.
// Zero-latency request and response paths; a different bank stalls until the current one drains.
module addr_dec_resp_mux_multi_outstanding #(
    parameter bit          AggregateGnt   = 1'b1,
    parameter int unsigned NumOut         = 32,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    addr_dec_resp_mux_multi_outstanding_if.slave bus
);
    localparam int unsigned LogNumOut = (NumOut > 1) ? $clog2(NumOut) : 1;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] OneCnt = CntWidth'(1);

    logic [CntWidth-1:0]      r_cnt;
    logic [LogNumOut-1:0]     r_sel;
    logic                     r_spurious;

    logic [NumOut-1:0]        w_add_oh;
    logic                     w_gnt_add;
    logic                     w_vld_sel;
    logic                     w_vld_other;
    logic [RespDataWidth-1:0] w_rdata_sel;
    logic                     w_retire;
    logic                     w_room_ok;
    logic                     w_bank_ok;
    logic                     w_issue_ok;
    logic                     w_gnt;
    logic                     w_push;
    logic [CntWidth-1:0]      w_cnt_nxt;

    // A single-port instance has nothing to decode, so every request maps to port 0.
    always_comb begin
        w_add_oh    = '0;
        w_gnt_add   = 1'b0;
        w_vld_sel   = 1'b0;
        w_vld_other = 1'b0;
        w_rdata_sel = '0;
        for (int i = 0; i < int'(NumOut); i++) begin
            if (NumOut == 1 || LogNumOut'(i) == bus.add_i) begin
                w_add_oh[i] = 1'b1;
                w_gnt_add   = bus.gnt_i[i];
            end
            if (LogNumOut'(i) == r_sel) begin
                w_vld_sel   = bus.vld_i[i];
                w_rdata_sel = bus.rdata_i[i];
            end else if (bus.vld_i[i]) begin
                w_vld_other = 1'b1;
            end
        end
    end

    assign w_retire   = (r_cnt != '0) && w_vld_sel;
    assign w_room_ok  = (r_cnt < MaxCnt) || w_retire;
    // Switching banks is safe only once the last response of the old bank is leaving.
    assign w_bank_ok  = (NumOut == 1) || (r_cnt == '0) || (bus.add_i == r_sel)
                        || ((r_cnt == OneCnt) && w_retire);
    assign w_issue_ok = w_room_ok && w_bank_ok;
    assign w_gnt      = w_issue_ok && (AggregateGnt ? (|bus.gnt_i) : w_gnt_add);
    assign w_push     = bus.req_i && w_gnt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_retire})
            2'b10:   w_cnt_nxt = r_cnt + OneCnt;
            2'b01:   w_cnt_nxt = r_cnt - OneCnt;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_sel      <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_push) begin
                r_sel <= (NumOut == 1) ? '0 : bus.add_i;
            end
            r_spurious <= w_vld_other || ((r_cnt == '0) && (|bus.vld_i));
        end
    end

    assign bus.req_o         = {NumOut{bus.req_i && w_issue_ok}} & w_add_oh;
    assign bus.gnt_o         = w_gnt;
    assign bus.vld_o         = w_retire;
    assign bus.rdata_o       = w_rdata_sel;
    assign bus.data_o        = {NumOut{bus.data_i}};
    assign bus.outstanding_o = r_cnt;
    assign bus.spurious_o    = r_spurious;
endmodule
